speed_loop: RTL and testbench

Outer velocity loop of the FOC datapath. Once per speed strobe it samples the 20-bit electrical angle, differentiates it into a signed speed estimate with wrap-around handling, and runs a saturating PI controller against a speed setpoint. It produces the q-axis current reference for the current loop. It sits between the encoder acquisition stage, which supplies the angle, and the current loop, which consumes `oIq_set`/`oId_set`, in the 100 MHz domain.

---
 rtl/speed_loop.sv | 159 +++++++++++++++
 tb/tb_speed_loop.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/speed_loop.sv
// speed_loop: outer velocity loop. Per speed strobe, differentiates the
// electrical angle into a signed speed, then runs a saturating PI controller
// against the setpoint to produce the q-axis current reference.
module speed_loop #(
    parameter logic [15:0] KP     = 16'd200,
    parameter logic [15:0] KI     = 16'd10,
    parameter int unsigned Q      = 12,
    parameter logic [15:0] IQ_MAX = 16'd8000
) (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic               iSL_en,
    input  logic [19:0]        iTheta_elec,
    input  logic signed [15:0] iSpeed_set,
    output logic signed [15:0] oSpeed,
    output logic signed [15:0] oIq_set,
    output logic signed [15:0] oId_set,
    output logic               oSL_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_DELTA, S_ERR, S_MULP, S_MULI, S_INT, S_OUT
    } state_t;

    localparam logic signed [33:0] INT_LIM = 34'(IQ_MAX) << Q;
    localparam logic signed [33:0] OUT_LIM = 34'(IQ_MAX);

    state_t             state_q, state_d;
    logic [19:0]        theta_cur_q, theta_cur_d;
    logic [19:0]        theta_prev_q, theta_prev_d;
    logic               prev_valid_q, prev_valid_d;
    logic signed [15:0] speed_q, speed_d;
    logic signed [15:0] err_q, err_d;
    logic signed [31:0] p_q, p_d;
    logic signed [31:0] inc_q, inc_d;
    logic signed [32:0] integ_q, integ_d;
    logic signed [15:0] speed_out_q, speed_out_d;
    logic signed [15:0] iq_q, iq_d;
    logic               done_q, done_d;

    logic signed [19:0] delta_s;
    logic signed [16:0] err17;
    logic [15:0]        gain;
    logic signed [32:0] prod;
    logic signed [33:0] int_sum;
    logic signed [33:0] u_sum;
    logic signed [33:0] u_sh;

    // Shared datapath: delta, error, single multiplier, integrator and output sums
    always_comb begin
        delta_s = $signed(theta_cur_q - theta_prev_q);
        err17   = {iSpeed_set[15], iSpeed_set} - {speed_q[15], speed_q};
        gain    = (state_q == S_MULP) ? KP : KI;
        prod    = $signed({1'b0, gain}) * err_q;
        int_sum = {integ_q[32], integ_q} + {{2{inc_q[31]}}, inc_q};
        u_sum   = {{2{p_q[31]}}, p_q} + {integ_q[32], integ_q};
        u_sh    = u_sum >>> Q;
    end

    // Next-state and register-update logic for the sample sequence
    always_comb begin
        state_d      = state_q;
        theta_cur_d  = theta_cur_q;
        theta_prev_d = theta_prev_q;
        prev_valid_d = prev_valid_q;
        speed_d      = speed_q;
        err_d        = err_q;
        p_d          = p_q;
        inc_d        = inc_q;
        integ_d      = integ_q;
        speed_out_d  = speed_out_q;
        iq_d         = iq_q;
        done_d       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (iSL_en) begin
                    theta_cur_d = iTheta_elec;
                    state_d     = S_DELTA;
                end
            end
            S_DELTA: begin
                if (!prev_valid_q)               speed_d = '0;
                else if (delta_s > 20'sd32767)   speed_d = 16'sh7FFF;
                else if (delta_s < -20'sd32768)  speed_d = 16'sh8000;
                else                             speed_d = delta_s[15:0];
                theta_prev_d = theta_cur_q;
                prev_valid_d = 1'b1;
                state_d      = S_ERR;
            end
            S_ERR: begin
                if (err17 > 17'sd32767)          err_d = 16'sh7FFF;
                else if (err17 < -17'sd32768)    err_d = 16'sh8000;
                else                             err_d = err17[15:0];
                state_d = S_MULP;
            end
            S_MULP: begin
                p_d     = prod[31:0];
                state_d = S_MULI;
            end
            S_MULI: begin
                inc_d   = prod[31:0];
                state_d = S_INT;
            end
            S_INT: begin
                // Clamp keeps the integrator inside the range the output can use
                if (int_sum > INT_LIM)           integ_d = INT_LIM[32:0];
                else if (int_sum < -INT_LIM)     integ_d = 33'(-INT_LIM);
                else                             integ_d = int_sum[32:0];
                state_d = S_OUT;
            end
            S_OUT: begin
                if (u_sh > OUT_LIM)              iq_d = IQ_MAX;
                else if (u_sh < -OUT_LIM)        iq_d = 16'(-OUT_LIM);
                else                             iq_d = u_sh[15:0];
                speed_out_d = speed_q;
                done_d      = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q      <= S_IDLE;
            theta_cur_q  <= '0;
            theta_prev_q <= '0;
            prev_valid_q <= 1'b0;
            speed_q      <= '0;
            err_q        <= '0;
            p_q          <= '0;
            inc_q        <= '0;
            integ_q      <= '0;
            speed_out_q  <= '0;
            iq_q         <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            theta_cur_q  <= theta_cur_d;
            theta_prev_q <= theta_prev_d;
            prev_valid_q <= prev_valid_d;
            speed_q      <= speed_d;
            err_q        <= err_d;
            p_q          <= p_d;
            inc_q        <= inc_d;
            integ_q      <= integ_d;
            speed_out_q  <= speed_out_d;
            iq_q         <= iq_d;
            done_q       <= done_d;
        end
    end

    assign oSpeed   = speed_out_q;
    assign oIq_set  = iq_q;
    assign oId_set  = '0;
    assign oSL_done = done_q;

endmodule

// File: tb/tb_speed_loop.sv
// Scoreboard bench for speed_loop: a driver issues strobes and pushes the
// reference model's prediction; a monitor pops and compares on oSL_done.
module tb_speed_loop;

    localparam longint KP     = 200;
    localparam longint KI     = 10;
    localparam int     Q      = 12;
    localparam longint IQ_MAX = 8000;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               sl_en = 1'b0;
    logic [19:0]        theta = '0;
    logic signed [15:0] sset = '0;
    logic signed [15:0] o_speed;
    logic signed [15:0] o_iq;
    logic signed [15:0] o_id;
    logic               o_done;

    speed_loop #(
        .KP(16'd200), .KI(16'd10), .Q(12), .IQ_MAX(16'd8000)
    ) dut (
        .iClk(clk), .iRst_n(rst_n), .iSL_en(sl_en), .iTheta_elec(theta),
        .iSpeed_set(sset), .oSpeed(o_speed), .oIq_set(o_iq), .oId_set(o_id),
        .oSL_done(o_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int speed;
        int iq;
        int due;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int dones  = 0;

    // Reference model state
    logic [19:0] m_prev  = '0;
    bit          m_valid = 1'b0;
    longint      m_integ = 0;

    function automatic longint clampl(input longint v, input longint lo, input longint hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_prev  = '0;
        m_valid = 1'b0;
        m_integ = 0;
    endtask

    // Speed from the angle difference taken on the 2^20 circle, then PI with
    // floor division by 2^Q and magnitude limits.
    task automatic model_step(input logic [19:0] th, input longint sp,
                              output int spd, output int iq);
        longint d, err, p, inc, lim, div, s, u;
        d = (longint'(th) - longint'(m_prev)) % 1048576;
        if (d < 0) d += 1048576;
        if (d >= 524288) d -= 1048576;
        spd = int'(clampl(d, -32768, 32767));
        if (!m_valid) spd = 0;
        m_valid = 1'b1;
        m_prev  = th;
        err = clampl(sp - longint'(spd), -32768, 32767);
        p   = KP * err;
        inc = KI * err;
        div = longint'(1) << Q;
        lim = IQ_MAX * div;
        m_integ = clampl(m_integ + inc, -lim, lim);
        s = p + m_integ;
        if (s >= 0) u = s / div;
        else        u = -((-s + div - 1) / div);
        iq = int'(clampl(u, -IQ_MAX, IQ_MAX));
    endtask

    // Monitor: every done pulse must match the oldest outstanding prediction
    always @(negedge clk) begin
        if (rst_n && o_done) begin
            dones++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: oSL_done=1 with no strobe pending (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("oSpeed", longint'(o_speed), longint'(e.speed));
                check("oIq_set", longint'(o_iq), longint'(e.iq));
                check("done_latency", longint'(cyc), longint'(e.due));
                check("oId_set", longint'(o_id), 0);
            end
        end
    end

    task automatic strobe(input logic [19:0] th, input logic signed [15:0] sp, input int gap);
        int spd, iq;
        exp_t e;
        @(negedge clk);
        theta = th;
        sset  = sp;
        sl_en = 1'b1;
        model_step(th, longint'(sp), spd, iq);
        e.speed = spd;
        e.iq    = iq;
        e.due   = cyc + 7;
        sb.push_back(e);
        @(negedge clk);
        sl_en = 1'b0;
        theta = 20'($urandom);
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: %0d outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_oIq_set", longint'(o_iq), 0);
        check("rst_oSpeed", longint'(o_speed), 0);
        check("rst_oSL_done", longint'(o_done), 0);
        sb.delete();
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    logic [19:0] th_run;
    int          d0;

    initial begin
        // Reset held while strobing: outputs stay 0, no done
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sl_en = (i % 2 == 0);
            theta = 20'h12345;
            #1;
            check("hold_oSpeed", longint'(o_speed), 0);
            check("hold_oIq_set", longint'(o_iq), 0);
            check("hold_oId_set", longint'(o_id), 0);
            check("hold_oSL_done", longint'(o_done), 0);
        end
        @(negedge clk);
        sl_en = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // First sample after reset
        strobe(20'h12345, 16'sd0, 8);
        drain();

        // Steady speed and wrap-around in both directions
        do_reset();
        strobe(20'h00000, 16'sd256, 8);
        strobe(20'h00100, 16'sd256, 8);
        strobe(20'hFFF00, 16'sd0, 8);
        strobe(20'h00100, 16'sd0, 8);
        strobe(20'hFFF00, 16'sd0, 8);
        drain();

        // PI step, saturation and anti-windup, then reversed setpoint
        do_reset();
        for (int i = 0; i < 120; i++) strobe(20'h00000, 16'sd32767, 7);
        strobe(20'h00000, -16'sd32767, 7);
        drain();

        // Busy strobe three cycles into a computation is ignored
        d0 = dones;
        strobe(20'h00000, 16'sd500, 3);
        sl_en = 1'b1;
        theta = 20'h40000;
        @(negedge clk);
        sl_en = 1'b0;
        drain();
        repeat (10) @(negedge clk);
        check("busy_done_count", longint'(dones - d0), 1);

        // Reset asserted just before edge k+4 kills the computation
        @(negedge clk);
        theta = 20'h01000;
        sset  = 16'sd1000;
        sl_en = 1'b1;
        @(negedge clk);
        sl_en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midop_oIq_set", longint'(o_iq), 0);
        check("midop_oSpeed", longint'(o_speed), 0);
        model_reset();
        d0 = dones;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("midop_no_done", longint'(dones - d0), 0);
        strobe(20'h05000, 16'sd1000, 8);
        drain();

        // Randomized samples with varied angle steps, setpoints and spacing
        th_run = 20'h05000;
        for (int i = 0; i < 60; i++) begin
            int unsigned r;
            r = $urandom_range(0, 3);
            if (r == 0) th_run = 20'($urandom);
            else        th_run = th_run + 20'($urandom_range(0, 4000)) - 20'd2000;
            strobe(th_run, 16'($urandom), int'($urandom_range(7, 12)));
        end
        drain();
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
